// File: rtl/leitor_dht11.sv
// Host-side reader for a DHT11 sensor: drives the start pulse, times the sensor's
// single-wire response, decodes 40 bits and publishes humidity/temperature on a good checksum.
module leitor_dht11 #(
  parameter int CICLOS_POR_US = 50,
  parameter int INICIO_US     = 18000,
  parameter int TIMEOUT_US    = 100,
  parameter int LIMIAR_BIT_US = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        dht_in,
  output logic        dht_puxa_baixo,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        pronto,
  output logic        erro_checksum,
  output logic        erro_timeout,
  output logic        ocupado
);

  localparam int            PW       = (CICLOS_POR_US > 1) ? $clog2(CICLOS_POR_US) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CICLOS_POR_US - 1);
  // The cycle in which a transition is decided already counts as elapsed time,
  // so a measured level of N us reads exactly N when its closing edge is seen.
  localparam logic [PW-1:0] PRE_INI  = (CICLOS_POR_US > 1) ? PW'(1) : PW'(0);
  localparam logic [15:0]   INICIO_W = 16'(INICIO_US);
  localparam logic [15:0]   TMO_W    = 16'(TIMEOUT_US);
  localparam logic [15:0]   LIMIAR_W = 16'(LIMIAR_BIT_US);

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    INICIO_BAIXO    = 3'd1,
    ESPERA_RESPOSTA = 3'd2,
    RESP_BAIXO      = 3'd3,
    RESP_ALTO       = 3'd4,
    BIT_BAIXO       = 3'd5,
    BIT_ALTO        = 3'd6,
    VERIFICA        = 3'd7
  } estado_t;

  function automatic logic soma_ok(input logic [39:0] q);
    logic [7:0] s;
    s = q[39:32] + q[31:24] + q[23:16] + q[15:8];
    return (s == q[7:0]);
  endfunction

  estado_t       estado_q, estado_d;
  logic          sin1_q, sin2_q, sin3_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   us_q, us_d;
  logic [39:0]   shift_q, shift_d;
  logic [5:0]    nbits_q, nbits_d;
  logic [15:0]   temp_q, temp_d, umid_q, umid_d;
  logic          pronto_q, pronto_d, eck_q, eck_d, eto_q, eto_d;
  logic          puxa_q, ocup_q;
  logic          desce, sobe, estourou, tick, muda, bit_lido;

  assign desce    = sin3_q & ~sin2_q;
  assign sobe     = ~sin3_q & sin2_q;
  assign estourou = (us_q == TMO_W);
  assign tick     = (pre_q == PRE_MAX);
  assign muda     = (estado_d != estado_q);
  assign bit_lido = (us_q > LIMIAR_W);

  // Next state, frame assembly and result pulses.
  always_comb begin
    estado_d = estado_q;
    shift_d  = shift_q;
    nbits_d  = nbits_q;
    temp_d   = temp_q;
    umid_d   = umid_q;
    pronto_d = 1'b0;
    eck_d    = 1'b0;
    eto_d    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (iniciar) estado_d = INICIO_BAIXO;
        else         estado_d = OCIOSO;
      end
      INICIO_BAIXO: begin
        if (us_q == INICIO_W) estado_d = ESPERA_RESPOSTA;
        else                  estado_d = INICIO_BAIXO;
      end
      ESPERA_RESPOSTA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO: begin
        // The expected edge beats a timeout landing in the same cycle.
        if ((estado_q == RESP_BAIXO || estado_q == BIT_BAIXO) ? sobe : desce) begin
          if (estado_q == ESPERA_RESPOSTA)      estado_d = RESP_BAIXO;
          else if (estado_q == RESP_BAIXO)      estado_d = RESP_ALTO;
          else if (estado_q == BIT_BAIXO)       estado_d = BIT_ALTO;
          else if (estado_q == RESP_ALTO) begin
            estado_d = BIT_BAIXO;
            nbits_d  = 6'd0;
            shift_d  = 40'd0;
          end else begin
            shift_d  = {shift_q[38:0], bit_lido};
            nbits_d  = nbits_q + 6'd1;
            if (nbits_q == 6'd39) estado_d = VERIFICA;
            else                  estado_d = BIT_BAIXO;
          end
        end else if (estourou) begin
          eto_d    = 1'b1;
          estado_d = OCIOSO;
        end else begin
          estado_d = estado_q;
        end
      end
      VERIFICA: begin
        if (soma_ok(shift_q)) begin
          umid_d   = shift_q[39:24];
          temp_d   = shift_q[23:8];
          pronto_d = 1'b1;
        end else begin
          eck_d    = 1'b1;
        end
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Microsecond time base, restarted whenever the state changes.
  always_comb begin
    pre_d = pre_q;
    us_d  = us_q;
    if (muda) begin
      pre_d = PRE_INI;
      us_d  = 16'd0;
    end else if (tick) begin
      pre_d = '0;
      if (us_q != 16'hFFFF) us_d = us_q + 16'd1;
      else                  us_d = us_q;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // State, synchronizer, time base and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      sin1_q   <= 1'b1;
      sin2_q   <= 1'b1;
      sin3_q   <= 1'b1;
      pre_q    <= '0;
      us_q     <= 16'd0;
      shift_q  <= 40'd0;
      nbits_q  <= 6'd0;
      temp_q   <= 16'd0;
      umid_q   <= 16'd0;
      pronto_q <= 1'b0;
      eck_q    <= 1'b0;
      eto_q    <= 1'b0;
      puxa_q   <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sin1_q   <= dht_in;
      sin2_q   <= sin1_q;
      sin3_q   <= sin2_q;
      pre_q    <= pre_d;
      us_q     <= us_d;
      shift_q  <= shift_d;
      nbits_q  <= nbits_d;
      temp_q   <= temp_d;
      umid_q   <= umid_d;
      pronto_q <= pronto_d;
      eck_q    <= eck_d;
      eto_q    <= eto_d;
      puxa_q   <= (estado_d == INICIO_BAIXO);
      ocup_q   <= (estado_d != OCIOSO);
    end
  end

  assign dht_puxa_baixo = puxa_q;
  assign temperatura    = temp_q;
  assign umidade        = umid_q;
  assign pronto         = pronto_q;
  assign erro_checksum  = eck_q;
  assign erro_timeout   = eto_q;
  assign ocupado        = ocup_q;

endmodule

// File: doc/leitor_dht11.md
Name: leitor_dht11

Overview:
- Single-wire reader for a DHT11 temperature/humidity sensor.
- Produces the 16-bit temperature and humidity words consumed by tusca_fd, in the {integer byte, decimal byte} format: upper 8 bits are the integer part, lower 8 bits are tenths.
- Acts as the host end of the sensor protocol: issues the start pulse, decodes 40 data bits and checks the checksum.
- Publishes values only on a valid frame.

Parameters:
- CICLOS_POR_US, 50, clock cycles per microsecond (50 MHz board clock).
- INICIO_US, 18000, length of the host start pulse (line driven low), in µs.
- TIMEOUT_US, 100, maximum duration of any single sensor line level before abort, in µs.
- LIMIAR_BIT_US, 40, a high time strictly greater than this decodes as bit 1, otherwise bit 0.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- iniciar, input, 1, single-cycle request to start one measurement; ignored while busy.
- dht_in, input, 1, raw sensor data line (asynchronous; pad has a pull-up).
- dht_puxa_baixo, output, 1, 1 means the open-drain pad drives the line low; 0 releases it.
- temperatura, output, 16, last valid temperature as {int, dec}.
- umidade, output, 16, last valid humidity as {int, dec}.
- pronto, output, 1, one-cycle pulse when a valid frame has updated the outputs.
- erro_checksum, output, 1, one-cycle pulse when a frame completes with a bad checksum.
- erro_timeout, output, 1, one-cycle pulse when a protocol phase times out.
- ocupado, output, 1, high from acceptance of iniciar until return to OCIOSO.

Behaviour:
- Reset is synchronous, active-high and dominant over all other inputs. Reset values:
  - state OCIOSO;
  - dht_puxa_baixo 0;
  - temperatura and umidade 0x0000;
  - pronto, erro_checksum, erro_timeout, ocupado all 0;
  - shift register, bit counter, µs prescaler and µs counter all 0.
- Reset mid-transaction releases the line on the next edge and discards any partial frame.
- dht_in passes through a 2-flop synchronizer. All edge detection uses the synchronized value and its 1-cycle-delayed copy.
- Timing base:
  - A prescaler wraps at CICLOS_POR_US-1 and emits a 1-cycle µs tick.
  - A µs counter (16 bits, saturating) clears on every state transition.
  - Both prescaler and µs counter restart at each transition.
- FSM states and transitions:
  - OCIOSO: if iniciar, go to INICIO_BAIXO and raise ocupado.
  - INICIO_BAIXO: dht_puxa_baixo=1. When the µs counter reaches INICIO_US, release the line and go to ESPERA_RESPOSTA.
  - ESPERA_RESPOSTA: on a synchronized falling edge, go to RESP_BAIXO.
  - RESP_BAIXO (sensor's ~80 µs low): on a rising edge, go to RESP_ALTO.
  - RESP_ALTO (~80 µs high): on a falling edge, go to BIT_BAIXO with the bit counter at 0.
  - BIT_BAIXO (~50 µs low): on a rising edge, go to BIT_ALTO.
  - BIT_ALTO: on a falling edge, shift bit = (µs counter > LIMIAR_BIT_US) into the LSB of a 40-bit shift register (MSB of the frame first) and increment the bit counter. If the counter is now 40, go to VERIFICA; else go to BIT_BAIXO.
  - VERIFICA (1 cycle):
    - Frame bytes are B4..B0 = hum_int, hum_dec, temp_int, temp_dec, checksum.
    - Valid when (B4+B3+B2+B1) mod 256 == B0. Then umidade <= {B4,B3}, temperatura <= {B2,B1}, pulse pronto.
    - Otherwise pulse erro_checksum and hold the outputs unchanged.
    - Then go to OCIOSO.
- Timeout:
  - Applies in every state from ESPERA_RESPOSTA through BIT_ALTO.
  - If the µs counter reaches TIMEOUT_US before the expected edge, pulse erro_timeout and go to OCIOSO.
  - Line stays released; outputs are unchanged.
- Edge-vs-timeout race: if the expected edge and the timeout arrive in the same cycle, the edge wins.
- The final falling edge of bit 40 ends the frame. The sensor's trailing release is not waited for.
- iniciar asserted in any state other than OCIOSO is ignored. It is not queued.
- ocupado falls in the same cycle the FSM enters OCIOSO, coincident with any pronto or error pulse.
- Decode latency: pronto asserts 1 cycle after the registered falling edge of bit 40, i.e. about 3 cycles after the raw line edge including the synchronizer.

Test Plan:
- Bench setup: CICLOS_POR_US=2, INICIO_US=20. A sensor model drives 80/80 µs response, 50 µs bit-low, 27 µs high for 0 and 70 µs high for 1.
- Valid frame: frame 0x30 0x02 0x19 0x08 0x53 -> umidade=0x3002 (48.2), temperatura=0x1908 (25.8), single pronto pulse, ocupado low afterwards, dht_puxa_baixo high for exactly 20 µs at start.
- Bad checksum: frame 0x30 0x02 0x19 0x08 0x54 after the valid frame -> erro_checksum pulse, no pronto, outputs remain 0x3002 and 0x1908.
- No sensor (line held high after start) -> erro_timeout exactly 100 µs after release, FSM in OCIOSO, outputs unchanged.
- Line stuck: sensor stalls high during bit 17 -> erro_timeout; a new iniciar then completes a valid frame 0x1E 0x00 0x14 0x05 0x37 -> umidade=0x1E00, temperatura=0x1405.
- Busy and reset:
  - iniciar pulsed during BIT_BAIXO -> ignored, only one transaction runs.
  - reset asserted during INICIO_BAIXO -> next cycle dht_puxa_baixo=0, all outputs 0, FSM in OCIOSO.
- Threshold boundary: bit-high of exactly 40 µs -> decoded 0; 41 µs -> decoded 1. Verify by checking the corresponding bit of temperatura.
